// File: rtl/weight_patch_feeder.sv
// Kernel weight store plus a streaming read path: replays one kernel's taps patch after
// patch into the systolic array weight input over a valid/ready link with credit-based
// backpressure.
module weight_patch_feeder #(
   parameter int unsigned K_R         = 3,
   parameter int unsigned K_S         = 3,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned NUM_KERNELS = 4,
   parameter int unsigned FIFO_DEPTH  = 2,
   parameter int unsigned PATCH_W     = 16
) (
   input  logic                               clk_i,
   input  logic                               rst_async_i,
   input  logic                               wr_en_i,
   input  logic [$clog2(NUM_KERNELS)-1:0]     wr_kernel_i,
   input  logic [$clog2(K_R*K_S):0]           wr_tap_i,
   input  logic [DATA_W-1:0]                  wr_data_i,
   output logic                               wr_err_o,
   input  logic                               start_i,
   input  logic [$clog2(NUM_KERNELS)-1:0]     kernel_sel_i,
   input  logic [PATCH_W-1:0]                 num_patches_i,
   output logic                               busy_o,
   output logic                               done_o,
   output logic                               w_valid_o,
   input  logic                               w_ready_i,
   output logic [DATA_W-1:0]                  w_data_o,
   output logic [$clog2(K_R*K_S):0]           w_tap_o,
   output logic                               w_last_o,
   output logic                               w_final_o
);

   localparam int unsigned Taps    = K_R * K_S;
   localparam int unsigned TapW    = $clog2(Taps) + 1;
   localparam int unsigned KselW   = $clog2(NUM_KERNELS);
   localparam int unsigned Entries = NUM_KERNELS * Taps;
   localparam int unsigned AddrW   = $clog2(Entries);
   localparam int unsigned BeatW   = DATA_W + TapW + 2;
   localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

   state_e               state_q, state_d;
   logic [KselW-1:0]     ksel_q;
   logic [PATCH_W-1:0]   npatch_q;
   logic [TapW-1:0]      tap_q;
   logic [PATCH_W-1:0]   patch_q;
   logic                 wr_err_q;

   logic [DATA_W-1:0]    mem_q [Entries];
   logic [DATA_W-1:0]    rd_data_q;
   logic                 rd_vld_q;
   logic [TapW-1:0]      rd_tap_q;
   logic                 rd_last_q;
   logic                 rd_final_q;

   logic [BeatW-1:0]     fifo_q [FIFO_DEPTH];
   logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]      cnt_q;
   logic [BeatW-1:0]     head;

   logic                 wr_ok, issue, pop, tap_last, final_rd;
   logic [AddrW-1:0]     wr_addr, rd_addr;

   assign wr_ok    = (state_q == StIdle) && (32'(wr_tap_i) < Taps);
   assign wr_addr  = AddrW'(32'(wr_kernel_i) * Taps + 32'(wr_tap_i));
   assign rd_addr  = AddrW'(32'(ksel_q) * Taps + 32'(tap_q));
   assign tap_last = (32'(tap_q) == Taps - 1);
   assign final_rd = tap_last && (32'(patch_q) == 32'(npatch_q) - 32'd1);
   assign pop      = w_valid_o && w_ready_i;
   // Credits: buffered beats plus the read in flight, minus the beat leaving this cycle.
   assign issue    = (state_q == StStream) &&
                     ((32'(cnt_q) + 32'(rd_vld_q) - 32'(pop)) < FIFO_DEPTH);

   assign head      = fifo_q[rd_ptr_q];
   assign w_valid_o = (cnt_q != '0);
   assign w_data_o  = head[DATA_W-1:0];
   assign w_tap_o   = head[DATA_W +: TapW];
   assign w_last_o  = head[DATA_W + TapW];
   assign w_final_o = head[BeatW-1];
   assign busy_o    = (state_q == StStream) || (state_q == StDrain);
   assign done_o    = (state_q == StDone);
   assign wr_err_o  = wr_err_q;

   // Next-state logic for the stream controller.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start_i) state_d = (num_patches_i != '0) ? StStream : StDone;
         StStream: if (issue && final_rd) state_d = StDrain;
         StDrain:  if (pop && w_final_o) state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // State register, start latching, tap/patch counters and write-error pulse.
   always_ff @(posedge clk_i or posedge rst_async_i) begin
      if (rst_async_i) begin
         state_q  <= StIdle;
         ksel_q   <= '0;
         npatch_q <= '0;
         tap_q    <= '0;
         patch_q  <= '0;
         wr_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_err_q <= wr_en_i && !wr_ok;
         if (state_q == StIdle && start_i) begin
            ksel_q   <= kernel_sel_i;
            npatch_q <= num_patches_i;
            tap_q    <= '0;
            patch_q  <= '0;
         end else if (issue) begin
            if (tap_last) begin
               tap_q   <= '0;
               patch_q <= patch_q + PATCH_W'(1);
            end else begin
               tap_q <= tap_q + TapW'(1);
            end
         end
      end
   end

   // Weight storage: synchronous write, registered read (contents survive reset).
   always_ff @(posedge clk_i) begin
      if (wr_en_i && wr_ok) mem_q[wr_addr] <= wr_data_i;
      if (issue) rd_data_q <= mem_q[rd_addr];
   end

   // Read-pipeline sidebands travel alongside the registered memory data.
   always_ff @(posedge clk_i or posedge rst_async_i) begin
      if (rst_async_i) begin
         rd_vld_q   <= 1'b0;
         rd_tap_q   <= '0;
         rd_last_q  <= 1'b0;
         rd_final_q <= 1'b0;
      end else begin
         rd_vld_q <= issue;
         if (issue) begin
            rd_tap_q   <= tap_q;
            rd_last_q  <= tap_last;
            rd_final_q <= final_rd;
         end
      end
   end

   // Output FIFO; storage is cleared on reset so every output reads 0.
   always_ff @(posedge clk_i or posedge rst_async_i) begin
      if (rst_async_i) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (rd_vld_q) begin
            fifo_q[wr_ptr_q] <= {rd_final_q, rd_last_q, rd_tap_q, rd_data_q};
            wr_ptr_q <= (32'(wr_ptr_q) == FIFO_DEPTH - 1) ? '0 : wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= (32'(rd_ptr_q) == FIFO_DEPTH - 1) ? '0 : rd_ptr_q + PtrW'(1);
         end
         cnt_q <= cnt_q + CntW'(rd_vld_q) - CntW'(pop);
      end
   end

endmodule

// File: tb/tb_weight_patch_feeder.sv
// Randomized bench for weight_patch_feeder: a tap/patch replay model built from plain
// nested loops over a weight array predicts every beat, done timing and write errors.
module tb_weight_patch_feeder;

   localparam int Taps = 9;

   logic        clk = 1'b0;
   logic        rst_async_i;
   logic        wr_en_i;
   logic [1:0]  wr_kernel_i;
   logic [4:0]  wr_tap_i;
   logic [7:0]  wr_data_i;
   logic        wr_err_o;
   logic        start_i;
   logic [1:0]  kernel_sel_i;
   logic [15:0] num_patches_i;
   logic        busy_o, done_o, w_valid_o, w_ready_i;
   logic [7:0]  w_data_o;
   logic [4:0]  w_tap_o;
   logic        w_last_o, w_final_o;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]  wmem [4][Taps];
   logic [14:0] exp_q [$];

   weight_patch_feeder dut (
      .clk_i         (clk),
      .rst_async_i   (rst_async_i),
      .wr_en_i       (wr_en_i),
      .wr_kernel_i   (wr_kernel_i),
      .wr_tap_i      (wr_tap_i),
      .wr_data_i     (wr_data_i),
      .wr_err_o      (wr_err_o),
      .start_i       (start_i),
      .kernel_sel_i  (kernel_sel_i),
      .num_patches_i (num_patches_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .w_valid_o     (w_valid_o),
      .w_ready_i     (w_ready_i),
      .w_data_o      (w_data_o),
      .w_tap_o       (w_tap_o),
      .w_last_o      (w_last_o),
      .w_final_o     (w_final_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic write_w(input int k, input int t, input logic [7:0] d);
      logic acc;
      acc = (t < Taps);
      @(negedge clk);
      wr_en_i = 1'b1; wr_kernel_i = 2'(k); wr_tap_i = 5'(t); wr_data_i = d;
      @(negedge clk);
      wr_en_i = 1'b0;
      check("wr_err_idle", 32'(wr_err_o), 32'(!acc));
      if (acc) wmem[k][t] = d;
   endtask

   // rmode 0: ready held high, 1: random ready. Nonzero indices inject a second start,
   // a write while busy, or a reset once that many beats have been seen.
   task automatic run_stream(input int ksel, input int np, input int rmode,
                             input int start_again, input int wr_busy, input int rst_beat);
      int first_valid, beats, done_cnt, done_idx, final_hs;
      logic hold_pending, aborted;
      logic [14:0] held, cur, e;
      exp_q.delete();
      for (int p = 0; p < np; p++)
         for (int t = 0; t < Taps; t++)
            exp_q.push_back({(t == Taps - 1) && (p == np - 1), (t == Taps - 1), 5'(t),
                             wmem[ksel][t]});
      @(negedge clk);
      kernel_sel_i = 2'(ksel); num_patches_i = 16'(np); start_i = 1'b1; w_ready_i = 1'b1;
      first_valid = -1; beats = 0; done_cnt = 0; done_idx = -1; final_hs = -1;
      hold_pending = 1'b0; aborted = 1'b0; held = '0;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(negedge clk);
         start_i = (cyc == start_again);
         wr_en_i = (cyc == wr_busy);
         wr_kernel_i = 2'd1; wr_tap_i = 5'd0; wr_data_i = 8'hFF;
         if (wr_busy != 0 && cyc == wr_busy + 1) check("wr_err_busy", 32'(wr_err_o), 32'd1);
         if (cyc == 1) check("busy_after_start", 32'(busy_o), 32'd1);
         w_ready_i = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         cur = {w_final_o, w_last_o, w_tap_o, w_data_o};
         if (hold_pending) check("hold_stable", {16'd0, w_valid_o, cur}, {16'd0, 1'b1, held});
         if (w_valid_o && first_valid < 0) first_valid = cyc;
         if (done_o) begin
            done_cnt++;
            if (done_idx < 0) done_idx = cyc;
            check("busy_at_done", 32'(busy_o), 32'd0);
         end
         if (w_valid_o && w_ready_i) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 32'(cur), 32'h7FFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("beat", 32'(cur), 32'(e));
            end
            beats++;
            if (w_final_o) final_hs = cyc;
         end
         hold_pending = w_valid_o && !w_ready_i;
         held = cur;
         if (rst_beat != 0 && beats == rst_beat) begin
            rst_async_i = 1'b1;
            #1;
            check("rst_mid_outputs", {29'd0, w_valid_o, busy_o, done_o}, 32'd0);
            start_i = 1'b0; wr_en_i = 1'b0; w_ready_i = 1'b0;
            @(negedge clk);
            check("rst_hold_outputs", {29'd0, w_valid_o, busy_o, done_o}, 32'd0);
            @(negedge clk);
            rst_async_i = 1'b0;
            aborted = 1'b1;
            break;
         end
         if (done_idx > 0 && cyc >= done_idx + 2) break;
      end
      start_i = 1'b0; wr_en_i = 1'b0;
      if (!aborted) begin
         check("first_valid_cycle", 32'(first_valid), 32'd3);
         check("beat_count", 32'(beats), 32'(np * Taps));
         check("done_count", 32'(done_cnt), 32'd1);
         check("done_after_final", 32'(done_idx), 32'(final_hs + 1));
      end
   endtask

   initial begin
      int zp_valid, zp_busy, zp_done_first, zp_done_other;
      rst_async_i = 1'b1; wr_en_i = 1'b0; wr_kernel_i = '0; wr_tap_i = '0; wr_data_i = '0;
      start_i = 1'b0; kernel_sel_i = '0; num_patches_i = '0; w_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {15'd0, w_valid_o, busy_o, done_o, wr_err_o, w_last_o,
                              w_final_o, w_tap_o, w_data_o}, 32'd0);
      rst_async_i = 1'b0;

      for (int t = 0; t < Taps; t++) write_w(1, t, 8'(8'h10 + t));
      for (int k = 0; k < 4; k++)
         if (k != 1)
            for (int t = 0; t < Taps; t++) write_w(k, t, 8'($urandom));

      run_stream(1, 2, 0, 0, 0, 0);
      run_stream(1, 2, 1, 0, 0, 0);

      // Zero-patch start: done next cycle, no beats, never busy.
      @(negedge clk);
      kernel_sel_i = 2'd1; num_patches_i = 16'd0; start_i = 1'b1; w_ready_i = 1'b1;
      zp_valid = 0; zp_busy = 0; zp_done_first = 0; zp_done_other = 0;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         @(negedge clk);
         start_i = 1'b0;
         zp_valid += int'(w_valid_o);
         zp_busy  += int'(busy_o);
         if (cyc == 1) zp_done_first = int'(done_o);
         else zp_done_other += int'(done_o);
      end
      check("zero_np_valid", 32'(zp_valid), 32'd0);
      check("zero_np_busy", 32'(zp_busy), 32'd0);
      check("zero_np_done", 32'(zp_done_first), 32'd1);
      check("zero_np_done_once", 32'(zp_done_other), 32'd0);

      run_stream(1, 1, 0, 0, 3, 0);
      write_w(1, 9, 8'h55);
      write_w(1, 20, 8'h66);
      run_stream(1, 1, 1, 0, 0, 0);

      run_stream(2, 3, 1, 5, 0, 0);
      run_stream(3, 2, 1, 0, 0, 5);
      run_stream(3, 2, 0, 0, 0, 0);

      for (int t = 0; t < Taps; t++) write_w(0, t, 8'($urandom));
      for (int i = 0; i < 4; i++)
         run_stream(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 1, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
